// File: rtl/fib_scheduler.sv
// Step scheduler for a Fibonacci datapath.
// It issues periodic advance pulses, detects when the datapath value wraps
// around, and raises a completion interrupt when a run ends.
module fib_scheduler #(
  parameter int unsigned CLOCK_WIDTH = 6,
  parameter int unsigned VAL_WIDTH   = 30
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n,
  input  logic                   switch_in,
  input  logic [CLOCK_WIDTH-1:0] clock_op,
  input  logic                   start,
  input  logic [15:0]            step_limit,
  input  logic [VAL_WIDTH-1:0]   fib_val,
  input  logic                   irq_ack,
  output logic                   fib_step,
  output logic                   fib_clear,
  output logic                   busy,
  output logic                   done_irq,
  output logic                   wrap_err,
  output logic [15:0]            step_count,
  output logic [1:0]             state
);

  localparam int unsigned CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             state_next;
  logic [CLOCK_WIDTH-1:0] div;
  logic [CLOCK_WIDTH-1:0] div_next;
  logic [VAL_WIDTH-1:0]   saved;
  logic [VAL_WIDTH-1:0]   saved_next;
  logic [CNT_WIDTH-1:0]   count_next;
  logic                   wrap_next;
  logic                   step_next;
  logic                   clear_next;
  logic                   eval;
  logic                   fire;
  logic                   limit_hit;

  // The divider counts cycles already spent in the current step period; the
  // decision for the next cycle is taken now so the pulse itself is registered.
  assign fire      = (clock_op != '0) && (div >= clock_op - CLOCK_WIDTH'(1));
  assign limit_hit = (step_limit != '0) && (step_count >= step_limit);

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, step decision and next values of the registered outputs.
  always_comb begin
    state_next = state;
    div_next   = div;
    saved_next = saved;
    count_next = step_count;
    wrap_next  = wrap_err;
    step_next  = 1'b0;
    clear_next = 1'b0;
    eval       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && switch_in) begin
          state_next = S_CLEAR;
          clear_next = 1'b1;
          div_next   = '0;
          saved_next = '0;
          count_next = '0;
          wrap_next  = 1'b0;
        end
      end
      S_CLEAR: begin
        if (!switch_in) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_RUN;
          eval       = 1'b1;
        end
      end
      S_RUN: begin
        if (!switch_in) begin
          state_next = S_IDLE;
        end else if (limit_hit) begin
          state_next = S_DONE;
        end else begin
          eval = 1'b1;
        end
      end
      default: begin
        if (irq_ack) begin
          state_next = S_IDLE;
        end
      end
    endcase

    // Period elapsed: either advance the datapath or stop on a wrapped value.
    if (eval) begin
      if (fire) begin
        div_next = '0;
        if ((step_count != '0) && (fib_val < saved)) begin
          wrap_next  = 1'b1;
          state_next = S_DONE;
        end else begin
          step_next  = 1'b1;
          saved_next = fib_val;
          count_next = (step_count == CNT_MAX) ? CNT_MAX : step_count + CNT_WIDTH'(1);
        end
      end else if (clock_op != '0) begin
        div_next = div + CLOCK_WIDTH'(1);
      end
    end
  end

  // Registered outputs and run bookkeeping.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      fib_step   <= 1'b0;
      fib_clear  <= 1'b0;
      busy       <= 1'b0;
      done_irq   <= 1'b0;
      wrap_err   <= 1'b0;
      step_count <= '0;
      div        <= '0;
      saved      <= '0;
    end else begin
      fib_step   <= step_next;
      fib_clear  <= clear_next;
      busy       <= (state_next == S_CLEAR) || (state_next == S_RUN);
      done_irq   <= (state_next == S_DONE);
      wrap_err   <= wrap_next;
      step_count <= count_next;
      div        <= div_next;
      saved      <= saved_next;
    end
  end

endmodule

// File: tb/tb_fib_scheduler.sv
// Self-checking bench for fib_scheduler.
module tb_fib_scheduler;

  localparam int unsigned CW = 6;
  localparam int unsigned VW = 30;

  logic          clk;
  logic          rst_n;
  logic          switch_in;
  logic [CW-1:0] clock_op;
  logic          start;
  logic [15:0]   step_limit;
  logic [VW-1:0] fib_val;
  logic          irq_ack;
  logic          fib_step;
  logic          fib_clear;
  logic          busy;
  logic          done_irq;
  logic          wrap_err;
  logic [15:0]   step_count;
  logic [1:0]    state;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  typedef struct {
    logic [CW-1:0] clk_op;
    logic [15:0]   limit;
    int            exp_count;
    int            exp_done_cyc;
  } vec_t;

  vec_t vecs[4];

  fib_scheduler #(.CLOCK_WIDTH(CW), .VAL_WIDTH(VW)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .switch_in (switch_in),
    .clock_op  (clock_op),
    .start     (start),
    .step_limit(step_limit),
    .fib_val   (fib_val),
    .irq_ack   (irq_ack),
    .fib_step  (fib_step),
    .fib_clear (fib_clear),
    .busy      (busy),
    .done_irq  (done_irq),
    .wrap_err  (wrap_err),
    .step_count(step_count),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int done_cyc;
    int n_extra;
    clock_op   = v.clk_op;
    step_limit = v.limit;
    switch_in  = 1'b1;
    fib_val    = VW'(1);
    for (int k = 1; k <= int'(v.limit); k++) exp_q.push_back(k * int'(v.clk_op));
    start_run();
    check("vec_clear_state", int'(state), 1);
    check("vec_clear_pulse", int'(fib_clear), 1);
    done_cyc = 0;
    n_extra  = 0;
    for (int cyc = 1; cyc <= 200 && done_cyc == 0; cyc++) begin
      tick();
      fib_val = fib_val + VW'(1);
      if (fib_step) begin
        if (exp_q.size() == 0) n_extra++;
        else check("vec_step_cycle", cyc, exp_q.pop_front());
      end
      if (state == 2'd3) done_cyc = cyc;
    end
    check("vec_extra_steps", n_extra, 0);
    check("vec_missing_steps", exp_q.size(), 0);
    exp_q.delete();
    check("vec_done_cycle", done_cyc, v.exp_done_cyc);
    check("vec_step_count", int'(step_count), v.exp_count);
    check("vec_done_irq", int'(done_irq), 1);
    check("vec_busy_done", int'(busy), 0);
    // start alone and switch_in low must not leave DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    check("vec_start_in_done", int'(state), 3);
    switch_in = 1'b0;
    tick();
    switch_in = 1'b1;
    check("vec_switch_in_done", int'(state), 3);
    // ack coincident with start returns to IDLE without a new CLEAR
    irq_ack = 1'b1;
    start   = 1'b1;
    tick();
    irq_ack = 1'b0;
    start   = 1'b0;
    check("vec_ack_state", int'(state), 0);
    check("vec_ack_irq", int'(done_irq), 0);
    tick();
    check("vec_no_clear_after_ack", int'(state), 0);
    check("vec_no_clear_pulse", int'(fib_clear), 0);
  endtask

  initial begin
    int nsteps;
    int done_cyc;
    int missed;
    int irq_seen;
    int wait_cyc;

    vecs[0] = '{clk_op: 6'd3, limit: 16'd4, exp_count: 4, exp_done_cyc: 13};
    vecs[1] = '{clk_op: 6'd1, limit: 16'd5, exp_count: 5, exp_done_cyc: 6};
    vecs[2] = '{clk_op: 6'd2, limit: 16'd3, exp_count: 3, exp_done_cyc: 7};
    vecs[3] = '{clk_op: 6'd5, limit: 16'd2, exp_count: 2, exp_done_cyc: 11};

    rst_n      = 1'b0;
    switch_in  = 1'b0;
    clock_op   = '0;
    start      = 1'b0;
    step_limit = '0;
    fib_val    = '0;
    irq_ack    = 1'b0;
    tick();
    tick();
    check("rst_state", int'(state), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_step", int'(fib_step), 0);
    check("rst_count", int'(step_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // start with switch_in low is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_start_no_switch", int'(state), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // wrap detection: values 5, 8, 3 at successive steps
    clock_op   = 6'd3;
    step_limit = 16'd0;
    switch_in  = 1'b1;
    fib_val    = VW'(5);
    start_run();
    nsteps   = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 30 && done_cyc == 0; cyc++) begin
      tick();
      if (fib_step) begin
        nsteps++;
        if (nsteps == 1) fib_val = VW'(8);
        if (nsteps == 2) fib_val = VW'(3);
      end
      if (state == 2'd3) begin
        done_cyc = cyc;
        check("wrap_no_step", int'(fib_step), 0);
      end
    end
    check("wrap_done_cycle", done_cyc, 9);
    check("wrap_steps", nsteps, 2);
    check("wrap_err_set", int'(wrap_err), 1);
    check("wrap_done_irq", int'(done_irq), 1);
    check("wrap_count", int'(step_count), 2);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("wrap_sticky_idle", int'(wrap_err), 1);
    start_run();
    check("wrap_cleared", int'(wrap_err), 0);
    check("clear_count_zero", int'(step_count), 0);
    switch_in = 1'b0;
    tick();
    check("abort_in_clear", int'(state), 0);
    switch_in = 1'b1;

    // abort mid-run at divider 4
    clock_op = 6'd8;
    start_run();
    nsteps = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fib_step) nsteps++;
    end
    switch_in = 1'b0;
    tick();
    check("abort_state", int'(state), 0);
    check("abort_step", int'(fib_step), 0);
    check("abort_irq", int'(done_irq), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_no_steps", nsteps, 0);
    switch_in = 1'b1;

    // pause, resume from held divider, then lower period below divider
    clock_op = 6'd3;
    start_run();
    wait_cyc = 0;
    for (int cyc = 1; cyc <= 10 && wait_cyc == 0; cyc++) begin
      tick();
      if (fib_step) wait_cyc = cyc;
    end
    check("pause_first_step", wait_cyc, 3);
    clock_op = 6'd0;
    nsteps = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fib_step) nsteps++;
    end
    check("pause_no_steps", nsteps, 0);
    clock_op = 6'd3;
    wait_cyc = 0;
    for (int cyc = 1; cyc <= 10 && wait_cyc == 0; cyc++) begin
      tick();
      if (fib_step) wait_cyc = cyc;
    end
    check("resume_step_delay", wait_cyc, 3);
    clock_op = 6'd8;
    nsteps = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fib_step) nsteps++;
    end
    check("lower_pre_steps", nsteps, 0);
    clock_op = 6'd3;
    tick();
    check("lower_fires_next", int'(fib_step), 1);
    check("lower_count", int'(step_count), 3);
    switch_in = 1'b0;
    tick();
    check("abort_retains_count", int'(step_count), 3);
    check("abort2_state", int'(state), 0);
    switch_in = 1'b1;

    // free-run saturation
    clock_op   = 6'd1;
    step_limit = 16'd0;
    fib_val    = '0;
    start_run();
    missed   = 0;
    irq_seen = 0;
    for (int i = 0; i < 70000; i++) begin
      tick();
      fib_val = fib_val + VW'(1);
      if (!fib_step) missed++;
      if (done_irq) irq_seen++;
    end
    check("sat_every_cycle", missed, 0);
    check("sat_count", int'(step_count), 32'h0000FFFF);
    check("sat_no_irq", irq_seen, 0);
    check("sat_state_run", int'(state), 2);

    // asynchronous reset mid-run
    tick();
    check("prereset_step", int'(fib_step), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", int'(state), 0);
    check("async_step", int'(fib_step), 0);
    check("async_clear", int'(fib_clear), 0);
    check("async_busy", int'(busy), 0);
    check("async_irq", int'(done_irq), 0);
    check("async_wrap", int'(wrap_err), 0);
    check("async_count", int'(step_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nsteps = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (state != 2'd0 || fib_step) nsteps++;
    end
    check("post_reset_idle", nsteps, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_scheduler.md
FIB_SCHEDULER -- requirements
Module: fib_scheduler

Interface
REQ-001 SHALL have parameter CLOCK_WIDTH, default 6, width of the step-period select.
REQ-002 SHALL have parameter VAL_WIDTH, default 30, width of the Fibonacci value observed from the datapath.
REQ-003 SHALL have port wb_clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port switch_in  input  1  datapath enable from the Wishbone register block.
REQ-006 SHALL have port clock_op  input  CLOCK_WIDTH  step period in cycles; 0 = paused.
REQ-007 SHALL have port start  input  1  run request, sampled each cycle.
REQ-008 SHALL have port step_limit  input  16  steps per run; 0 = free-run.
REQ-009 SHALL have port fib_val  input  VAL_WIDTH  current datapath value.
REQ-010 SHALL have port irq_ack  input  1  clears done_irq.
REQ-011 SHALL have port fib_step  output  1  one-cycle advance pulse to the datapath.
REQ-012 SHALL have port fib_clear  output  1  one-cycle datapath reseed pulse.
REQ-013 SHALL have port busy  output  1  high in CLEAR or RUN.
REQ-014 SHALL have port done_irq  output  1  completion interrupt, level.
REQ-015 SHALL have port wrap_err  output  1  sticky datapath wrap-around flag.
REQ-016 SHALL have port step_count  output  16  steps issued in the current/last run.
REQ-017 SHALL have port state  output  2  IDLE=0, CLEAR=1, RUN=2, DONE=3.

Function
REQ-018 SHALL implement FSM IDLE, CLEAR, RUN, DONE; all outputs registered.
REQ-019 IDLE: on start=1 and switch_in=1 SHALL go to CLEAR next cycle; start with switch_in=0 SHALL be ignored.
REQ-020 CLEAR: SHALL last exactly one cycle with fib_clear=1, and SHALL zero step_count, divider, wrap_err and the saved value; next state RUN.
REQ-021 RUN: divider SHALL count 0..clock_op-1; on the cycle divider >= clock_op-1 (clock_op != 0), fib_step SHALL be 1, divider SHALL return to 0, step_count SHALL increment.
REQ-022 First fib_step after CLEAR SHALL occur exactly clock_op cycles after the RUN entry cycle (clock_op=1: fib_step in every RUN cycle).
REQ-023 clock_op=0 in RUN SHALL hold the divider and issue no steps; nonzero clock_op SHALL resume counting from the held value.
REQ-024 clock_op lowered mid-run below the divider value SHALL fire fib_step on the next cycle (>= comparison).
REQ-025 On every fib_step, fib_val SHALL be saved; from the second step of a run, fib_val < saved value SHALL set wrap_err, suppress that step's fib_step, and go to DONE.
REQ-026 With step_limit != 0, the step that brings step_count to step_limit SHALL be issued, then the FSM SHALL go to DONE next cycle.
REQ-027 With step_limit = 0, stepping SHALL continue indefinitely; step_count SHALL saturate at 16'hFFFF.
REQ-028 switch_in=0 in CLEAR or RUN SHALL abort to IDLE next cycle, no fib_step, no done_irq; step_count retained.
REQ-029 DONE: done_irq SHALL be 1; irq_ack=1 SHALL clear done_irq and go to IDLE next cycle; start in DONE SHALL be ignored, including when coincident with irq_ack.
REQ-030 switch_in=0 in DONE SHALL not leave DONE.
REQ-031 wrap_err SHALL stay set until the next CLEAR or reset.
REQ-032 step_limit and clock_op SHALL be used live, not latched at start.

Reset
REQ-033 wb_rst_n=0 SHALL immediately force state=IDLE, fib_step=0, fib_clear=0, busy=0, done_irq=0, wrap_err=0, step_count=0, divider=0, saved value=0, regardless of clock.
REQ-034 Reset asserted mid-run SHALL drop fib_step within the same cycle; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-035 clock_op=3, step_limit=4, switch_in=1, start pulse -> fib_clear one cycle, fib_step at RUN cycles 3,6,9,12, step_count=4, done_irq=1, state=3.
REQ-036 From REQ-035 end, irq_ack=1 with start=1 same cycle -> done_irq=0, state=0 next cycle, no CLEAR.
REQ-037 clock_op=1, step_limit=0, fib_val incrementing, 70000 cycles -> fib_step every cycle, step_count=16'hFFFF, no done_irq.
REQ-038 fib_val sequence 5, 8, 3 at successive steps -> wrap_err=1 at third step, no fib_step that cycle, done_irq=1.
REQ-039 RUN with clock_op=8, drop switch_in at divider=4 -> state=0 next cycle, no fib_step, done_irq=0; also clock_op=0 for 20 cycles -> zero steps.
REQ-040 wb_rst_n low mid-cycle during RUN -> all outputs at reset values before next clock edge; after release start required to resume.
